// File: rtl/video_timing_rx.sv
// Sink-side 640x480 timing recovery: pixel coordinates, line/frame measurement and lock detection.
// Optional build macro VTRX_ERR_CNT_EN adds err_cnt, a saturating count of lock_err pulses.
module video_timing_rx #(
  parameter int H_TOTAL     = 800,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2,
  parameter int CW          = 11
) (
  input  logic          clk_pix,
  input  logic          rst_pix_n,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          de,
  output logic [CW-1:0] sx,
  output logic [CW-1:0] sy,
  output logic          active,
  output logic          frame_start,
  output logic [CW-1:0] h_total_o,
  output logic [CW-1:0] v_total_o,
  output logic          locked,
  output logic          lock_err
`ifdef VTRX_ERR_CNT_EN
  , output logic [15:0] err_cnt
`endif
);

  localparam logic [CW-1:0] MAXV   = '1;
  localparam logic [CW-1:0] HT_C   = CW'(H_TOTAL);
  localparam logic [CW-1:0] HA_C   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VT_C   = CW'(V_TOTAL);
  localparam logic [CW-1:0] VA_C   = CW'(V_ACTIVE);
  localparam logic [CW:0]   TO_LIM = (CW+1)'(2 * H_TOTAL);
  localparam logic [3:0]    LF_C   = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == MAXV) ? v : v + 1'b1;
  endfunction

  state_t        state;
  logic          hs_prev, vs_prev, de_prev;
  logic          fs_pend, armed, bad_line;
  logic [CW-1:0] h_cnt, v_cnt, a_cnt, de_run;
  logic [3:0]    match_cnt;

  logic          hs_edge, vs_edge, de_rise, de_fall;
  logic [CW-1:0] h_tot_new, de_run_new, v_tot_new, a_tot_new;
  logic          line_bad, frame_good, timeout;

  assign hs_edge = hs_prev & ~hsync;
  assign vs_edge = vs_prev & ~vsync;
  assign de_rise = de & ~de_prev;
  assign de_fall = ~de & de_prev;

  // Totals include the current cycle so an edge landing on the closing cycle is not lost.
  assign h_tot_new  = sat_inc(h_cnt);
  assign de_run_new = de ? sat_inc(de_run) : de_run;
  assign v_tot_new  = hs_edge ? sat_inc(v_cnt) : v_cnt;
  assign a_tot_new  = de_fall ? sat_inc(a_cnt) : a_cnt;

  // Blanking lines carry no de at all; only lines with data must have exactly H_ACTIVE of it.
  assign line_bad = hs_edge & armed &
                    ((h_tot_new != HT_C) || (h_tot_new == MAXV) ||
                     ((de_run_new != '0) && (de_run_new != HA_C)));

  assign frame_good = (v_tot_new == VT_C) && (v_tot_new != MAXV) &&
                      (a_tot_new == VA_C) && !(bad_line | line_bad);

  assign timeout = ({1'b0, h_cnt} >= TO_LIM) && !hs_edge;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      hs_prev     <= 1'b1;
      vs_prev     <= 1'b1;
      de_prev     <= 1'b0;
      active      <= 1'b0;
      frame_start <= 1'b0;
      fs_pend     <= 1'b0;
      sx          <= '0;
      sy          <= '0;
      h_cnt       <= '0;
      de_run      <= '0;
      v_cnt       <= '0;
      a_cnt       <= '0;
      h_total_o   <= '0;
      v_total_o   <= '0;
      armed       <= 1'b0;
      bad_line    <= 1'b0;
    end else begin
      hs_prev     <= hsync;
      vs_prev     <= vsync;
      de_prev     <= de;
      active      <= de;
      frame_start <= 1'b0;

      if (de_rise) begin
        sx <= '0;
        if (fs_pend) begin
          frame_start <= 1'b1;
          fs_pend     <= 1'b0;
        end
      end else if (de) begin
        sx <= sat_inc(sx);
      end
      if (vs_edge) fs_pend <= 1'b1;

      if (vs_edge)      sy <= '0;
      else if (de_fall) sy <= sat_inc(sy);

      // A line ending while still searching is never trusted for the next check.
      if (hs_edge) begin
        h_cnt     <= '0;
        de_run    <= '0;
        h_total_o <= h_tot_new;
        armed     <= (state != SEARCH);
      end else begin
        h_cnt  <= sat_inc(h_cnt);
        de_run <= de_run_new;
      end

      if (vs_edge) begin
        v_cnt     <= '0;
        a_cnt     <= '0;
        v_total_o <= v_tot_new;
        bad_line  <= 1'b0;
      end else begin
        v_cnt <= v_tot_new;
        a_cnt <= a_tot_new;
        if (line_bad) bad_line <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state     <= SEARCH;
      match_cnt <= '0;
      locked    <= 1'b0;
      lock_err  <= 1'b0;
`ifdef VTRX_ERR_CNT_EN
      err_cnt   <= '0;
`endif
    end else begin
      lock_err <= 1'b0;
      case (state)
        SEARCH: begin
          if (vs_edge) begin
            state     <= MEASURE;
            match_cnt <= '0;
          end
        end
        MEASURE: begin
          if (timeout) begin
            state     <= SEARCH;
            match_cnt <= '0;
          end else if (vs_edge) begin
            if (frame_good) begin
              match_cnt <= match_cnt + 4'd1;
              if (match_cnt + 4'd1 >= LF_C) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              match_cnt <= '0;
            end
          end
        end
        LOCKED: begin
          if (timeout || (vs_edge && !frame_good)) begin
            state     <= MEASURE;
            locked    <= 1'b0;
            match_cnt <= '0;
            lock_err  <= 1'b1;
`ifdef VTRX_ERR_CNT_EN
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
`endif
          end
        end
        default: begin
          state     <= SEARCH;
          match_cnt <= '0;
          locked    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_timing_rx.sv
// Directed bench for video_timing_rx on a scaled 40x20 raster; a per-cycle scoreboard holds the
// expected outputs for every driven pixel and checks them one clock later.
module tb_video_timing_rx;
  localparam int CW  = 11;
  localparam int HT  = 40;
  localparam int HA  = 32;
  localparam int HS0 = 34;
  localparam int HS1 = 38;
  localparam int VT  = 20;
  localparam int VA  = 16;
  localparam int VS0 = 17;
  localparam int VS1 = 19;
  // Hold cycle at which an hsync stall following a complete frame reaches 2*HT clocks.
  localparam int TO_K = 2*HT - (HT-1-HS0) + 1;

  logic          clk_pix = 1'b0;
  logic          rst_pix_n = 1'b0;
  logic          hsync = 1'b1;
  logic          vsync = 1'b1;
  logic          de = 1'b0;
  logic [CW-1:0] sx, sy, h_total_o, v_total_o;
  logic          active, frame_start, locked, lock_err;
  int            losses = 0;
`ifdef VTRX_ERR_CNT_EN
  logic [15:0]   err_cnt;
`endif

  typedef struct {
    logic          act;
    logic          fs;
    logic          lk;
    logic          le;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [CW-1:0] ht;
    logic [CW-1:0] vt;
    bit            tot;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  logic exp_lk = 1'b0;
  bit   fs_armed = 1'b0;

  always #5 clk_pix = ~clk_pix;

  video_timing_rx #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .V_TOTAL(VT), .V_ACTIVE(VA), .LOCK_FRAMES(2), .CW(CW)
  ) dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .hsync(hsync), .vsync(vsync), .de(de),
    .sx(sx), .sy(sy), .active(active), .frame_start(frame_start),
    .h_total_o(h_total_o), .v_total_o(v_total_o), .locked(locked), .lock_err(lock_err)
`ifdef VTRX_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".sx"}, 32'(sx), 32'd0);
    chk({tag, ".sy"}, 32'(sy), 32'd0);
    chk({tag, ".active"}, 32'(active), 32'd0);
    chk({tag, ".frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, ".h_total"}, 32'(h_total_o), 32'd0);
    chk({tag, ".v_total"}, 32'(v_total_o), 32'd0);
    chk({tag, ".locked"}, 32'(locked), 32'd0);
    chk({tag, ".lock_err"}, 32'(lock_err), 32'd0);
`ifdef VTRX_ERR_CNT_EN
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'd0);
`endif
  endtask

  // Check the entry pushed last cycle, then drive this cycle's inputs and queue their expectation.
  task automatic cyc(input logic h, input logic v, input logic d, input exp_t e);
    exp_t p;
    @(negedge clk_pix);
    if (sbq.size() > 0) begin
      p = sbq.pop_front();
      chk("active", 32'(active), 32'(p.act));
      chk("frame_start", 32'(frame_start), 32'(p.fs));
      if (p.act) begin
        chk("sx", 32'(sx), 32'(p.x));
        chk("sy", 32'(sy), 32'(p.y));
      end
      chk("locked", 32'(locked), 32'(p.lk));
      chk("lock_err", 32'(lock_err), 32'(p.le));
      if (p.tot) begin
        chk("h_total", 32'(h_total_o), 32'(p.ht));
        chk("v_total", 32'(v_total_o), 32'(p.vt));
      end
    end
    hsync = h;
    vsync = v;
    de    = d;
    sbq.push_back(e);
  endtask

  // One frame starting at pixel (0,0); lk_after/le_after are the lock outputs expected after its vsync edge.
  task automatic run_frame(input int nlines, input int long_line, input logic lk_after,
                           input logic le_after, input bit tot, input int vt, input int ncyc);
    exp_t e;
    logic h, v, d;
    int   hl;
    int   n = 0;
    for (int ln = 0; ln < nlines; ln++) begin
      hl = (ln == long_line) ? HT + 1 : HT;
      for (int x = 0; x < hl; x++) begin
        if (ncyc >= 0 && n >= ncyc) return;
        n++;
        d = (ln < VA) && (x < HA);
        h = !(x >= HS0 && x < HS1);
        v = !(ln >= VS0 && ln < VS1);
        e.act = d;  e.fs = 1'b0;  e.le = 1'b0;  e.tot = 1'b0;
        e.x = CW'(x);  e.y = CW'(ln);  e.ht = CW'(HT);  e.vt = CW'(vt);
        if (ln == 0 && x == 0) begin
          e.fs = fs_armed;
          fs_armed = 1'b0;
        end
        if (ln == VS0 && x == 0) begin
          fs_armed = 1'b1;
          exp_lk = lk_after;
          e.le = le_after;
          e.tot = tot;
          if (le_after) losses++;
        end
        e.lk = exp_lk;
        cyc(h, v, d, e);
      end
    end
  endtask

  task automatic hold_hsync(input int n);
    exp_t e;
    for (int k = 1; k <= n; k++) begin
      e.act = 1'b0;  e.fs = 1'b0;  e.le = 1'b0;  e.tot = 1'b0;
      e.x = '0;  e.y = '0;  e.ht = '0;  e.vt = '0;
      if (k == TO_K && exp_lk) begin
        exp_lk = 1'b0;
        e.le = 1'b1;
        losses++;
      end
      e.lk = exp_lk;
      cyc(1'b1, 1'b1, 1'b0, e);
    end
  endtask

  initial begin
    exp_t e;
    repeat (3) @(negedge clk_pix);
    chk_reset("reset");
    rst_pix_n = 1'b1;

    // Partial frame, then two good frames -> lock at the third vsync edge.
    run_frame(VT, -1, 1'b0, 1'b0, 1'b0, 0, -1);
    run_frame(VT, -1, 1'b0, 1'b0, 1'b1, VT, -1);
    run_frame(VT, -1, 1'b1, 1'b0, 1'b1, VT, -1);

    // One line stretched by a clock -> loss at the next vsync edge, relock after two frames.
    run_frame(VT, 5, 1'b0, 1'b1, 1'b1, VT, -1);
    run_frame(VT, -1, 1'b0, 1'b0, 1'b1, VT, -1);
    run_frame(VT, -1, 1'b1, 1'b0, 1'b1, VT, -1);

    // hsync stall past 2*HT -> loss and fall back to search.
    hold_hsync(100);
    run_frame(VT, -1, 1'b0, 1'b0, 1'b0, 0, -1);
    // Over-long frame clears the match count while still unlocked.
    run_frame(VT + 1, -1, 1'b0, 1'b0, 1'b1, VT, -1);
    run_frame(VT, -1, 1'b0, 1'b0, 1'b1, VT + 1, -1);
    run_frame(VT, -1, 1'b0, 1'b0, 1'b1, VT, -1);
    run_frame(VT, -1, 1'b1, 1'b0, 1'b1, VT, -1);
`ifdef VTRX_ERR_CNT_EN
    chk("err_cnt", 32'(err_cnt), 32'(losses));
`endif

    // Reset mid-line while locked: outputs clear without waiting for a clock.
    run_frame(VT, -1, 1'b1, 1'b0, 1'b0, 0, 4*HT + 16);
    #2;
    rst_pix_n = 1'b0;
    hsync = 1'b1;
    vsync = 1'b1;
    de    = 1'b0;
    #1;
    chk_reset("mid_reset");
    sbq.delete();
    exp_lk = 1'b0;
    fs_armed = 1'b0;
    repeat (2) @(negedge clk_pix);
    rst_pix_n = 1'b1;

    run_frame(VT, -1, 1'b0, 1'b0, 1'b0, 0, -1);
    run_frame(VT, -1, 1'b0, 1'b0, 1'b1, VT, -1);
    run_frame(VT, -1, 1'b1, 1'b0, 1'b1, VT, -1);

    e.act = 1'b0;  e.fs = 1'b0;  e.le = 1'b0;  e.tot = 1'b0;  e.lk = exp_lk;
    e.x = '0;  e.y = '0;  e.ht = '0;  e.vt = '0;
    cyc(1'b1, 1'b1, 1'b0, e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
